// File: rtl/rv32i_pipe_core_pkg.sv
// Shared definitions for the five-stage RV32I core: opcodes, funct3 codes, ALU ops and
// pipeline-register layouts.
package rv32i_pipe_core_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Sll  = 3'b001;
    localparam logic [2:0] F3Slt  = 3'b010;
    localparam logic [2:0] F3Sltu = 3'b011;
    localparam logic [2:0] F3Xor  = 3'b100;
    localparam logic [2:0] F3Sr   = 3'b101;
    localparam logic [2:0] F3Or   = 3'b110;
    localparam logic [2:0] F3And  = 3'b111;

    localparam logic [31:0] NopInst = 32'h00000013;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        a_pc;
        logic        a_zero;
        logic        b_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic [2:0]  funct3;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] wb_data;
    } mem_wb_t;

    // alt selects SUB/SRA; callers only raise it where the encoding allows.
    function automatic alu_op_e alu_op_decode(logic [2:0] f3, logic alt);
        case (f3)
            F3Add:   return alt ? AluSub : AluAdd;
            F3Sll:   return AluSll;
            F3Slt:   return AluSlt;
            F3Sltu:  return AluSltu;
            F3Xor:   return AluXor;
            F3Sr:    return alt ? AluSra : AluSrl;
            F3Or:    return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            AluSub:  return a - b;
            AluSll:  return a << sh;
            AluSlt:  return {31'b0, $signed(a) < $signed(b)};
            AluSltu: return {31'b0, a < b};
            AluXor:  return a ^ b;
            AluSrl:  return a >> sh;
            AluSra:  return 32'($signed(a) >>> sh);
            AluOr:   return a | b;
            AluAnd:  return a & b;
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_pipe_core_regfile.sv
// 32x32 register file: two asynchronous read ports, one write port, write-first bypass.
module rv32i_regfile
    import rv32i_pipe_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (we && rd_addr != 5'd0) begin
            registers[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (we && rd_addr == rs1_addr) begin
            rs1_data = rd_data;
        end else begin
            rs1_data = registers[rs1_addr];
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (we && rd_addr == rs2_addr) begin
            rs2_data = rd_data;
        end else begin
            rs2_data = registers[rs2_addr];
        end
    end

endmodule

// File: rtl/rv32i_pipe_core.sv
// Five-stage in-order RV32I core with EX/MEM and MEM/WB forwarding, load-use stall and
// branch resolution in EX.
module rv32i_pipe_core
    import rv32i_pipe_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_IF,
    input  logic [31:0] dm_read_data,
    output logic [3:0]  F_im_w_en,
    output logic [31:0] current_pc,
    output logic [31:0] reg_ex_mem_alu_out_out,
    output logic [3:0]  M_dm_w_en,
    output logic [31:0] reg_ex_mem_rs2_data_out
);

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    id_ex_t      id_ex_q, id_ex_d, id_ex_next;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        uses_rs1, uses_rs2, load_use;
    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res, ex_target;
    logic        ex_taken, br_cond;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    rv32i_regfile regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (if_id_q.inst[19:15]),
        .rs2_addr (if_id_q.inst[24:20]),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .we       (mem_wb_q.reg_write),
        .rd_addr  (mem_wb_q.rd),
        .rd_data  (mem_wb_q.wb_data)
    );

    // ID: decode
    always_comb begin
        logic [31:0] inst;
        inst = if_id_q.inst;
        id_ex_d = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        id_ex_d.valid = if_id_q.valid;
        id_ex_d.pc = if_id_q.pc;
        id_ex_d.rs1 = inst[19:15];
        id_ex_d.rs2 = inst[24:20];
        id_ex_d.rd = inst[11:7];
        id_ex_d.rs1_data = rf_rs1_data;
        id_ex_d.rs2_data = rf_rs2_data;
        id_ex_d.funct3 = inst[14:12];
        if (if_id_q.valid) begin
            case (inst[6:0])
                OpLui: begin
                    id_ex_d.imm = {inst[31:12], 12'b0};
                    id_ex_d.a_zero = 1'b1;
                    id_ex_d.b_imm = 1'b1;
                    id_ex_d.reg_write = 1'b1;
                end
                OpAuipc: begin
                    id_ex_d.imm = {inst[31:12], 12'b0};
                    id_ex_d.a_pc = 1'b1;
                    id_ex_d.b_imm = 1'b1;
                    id_ex_d.reg_write = 1'b1;
                end
                OpJal: begin
                    id_ex_d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                   inst[30:21], 1'b0};
                    id_ex_d.jal = 1'b1;
                    id_ex_d.reg_write = 1'b1;
                end
                OpJalr: begin
                    id_ex_d.imm = {{20{inst[31]}}, inst[31:20]};
                    id_ex_d.jalr = 1'b1;
                    id_ex_d.reg_write = 1'b1;
                    uses_rs1 = 1'b1;
                end
                OpBranch: begin
                    id_ex_d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                   inst[11:8], 1'b0};
                    id_ex_d.branch = 1'b1;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                OpLoad: begin
                    id_ex_d.imm = {{20{inst[31]}}, inst[31:20]};
                    id_ex_d.b_imm = 1'b1;
                    id_ex_d.mem_read = 1'b1;
                    id_ex_d.reg_write = 1'b1;
                    uses_rs1 = 1'b1;
                end
                OpStore: begin
                    id_ex_d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    id_ex_d.b_imm = 1'b1;
                    id_ex_d.mem_write = 1'b1;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                OpImm: begin
                    id_ex_d.imm = {{20{inst[31]}}, inst[31:20]};
                    id_ex_d.b_imm = 1'b1;
                    id_ex_d.alu_op = alu_op_decode(inst[14:12], inst[30] && inst[14:12] == F3Sr);
                    id_ex_d.reg_write = 1'b1;
                    uses_rs1 = 1'b1;
                end
                OpReg: begin
                    id_ex_d.alu_op = alu_op_decode(inst[14:12], inst[30]);
                    id_ex_d.reg_write = 1'b1;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign load_use = id_ex_q.mem_read && id_ex_q.rd != 5'd0 &&
                      ((uses_rs1 && id_ex_q.rd == if_id_q.inst[19:15]) ||
                       (uses_rs2 && id_ex_q.rd == if_id_q.inst[24:20]));

    // EX: forwarding, ALU, branch resolution. A load in EX/MEM is never a forward
    // source: the stall guarantees its consumer sees it from MEM/WB instead.
    always_comb begin
        fwd_a = id_ex_q.rs1_data;
        if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.rd != 5'd0 &&
            ex_mem_q.rd == id_ex_q.rs1) begin
            fwd_a = ex_mem_q.alu_out;
        end else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1) begin
            fwd_a = mem_wb_q.wb_data;
        end
        fwd_b = id_ex_q.rs2_data;
        if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.rd != 5'd0 &&
            ex_mem_q.rd == id_ex_q.rs2) begin
            fwd_b = ex_mem_q.alu_out;
        end else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2) begin
            fwd_b = mem_wb_q.wb_data;
        end

        op_a = id_ex_q.a_zero ? 32'd0 : (id_ex_q.a_pc ? id_ex_q.pc : fwd_a);
        op_b = id_ex_q.b_imm ? id_ex_q.imm : fwd_b;
        alu_res = alu_exec(id_ex_q.alu_op, op_a, op_b);

        case (id_ex_q.funct3)
            F3Beq:   br_cond = fwd_a == fwd_b;
            F3Bne:   br_cond = fwd_a != fwd_b;
            F3Blt:   br_cond = $signed(fwd_a) < $signed(fwd_b);
            F3Bge:   br_cond = $signed(fwd_a) >= $signed(fwd_b);
            F3Bltu:  br_cond = fwd_a < fwd_b;
            F3Bgeu:  br_cond = fwd_a >= fwd_b;
            default: br_cond = 1'b0;
        endcase
        ex_taken = id_ex_q.valid &&
                   (id_ex_q.jal || id_ex_q.jalr || (id_ex_q.branch && br_cond));
        ex_target = id_ex_q.jalr ? ((fwd_a + id_ex_q.imm) & ~32'd1) : (id_ex_q.pc + id_ex_q.imm);

        ex_mem_d.alu_out = (id_ex_q.jal || id_ex_q.jalr) ? id_ex_q.pc + 32'd4 : alu_res;
        case (id_ex_q.funct3[1:0])
            2'b00:   ex_mem_d.store_data = {4{fwd_b[7:0]}};
            2'b01:   ex_mem_d.store_data = {2{fwd_b[15:0]}};
            default: ex_mem_d.store_data = fwd_b;
        endcase
        ex_mem_d.rd = id_ex_q.rd;
        ex_mem_d.reg_write = id_ex_q.reg_write;
        ex_mem_d.mem_read = id_ex_q.mem_read;
        ex_mem_d.mem_write = id_ex_q.mem_write;
        ex_mem_d.funct3 = id_ex_q.funct3;
    end

    // MEM: byte enables and load extraction
    always_comb begin
        M_dm_w_en = 4'b0000;
        if (ex_mem_q.mem_write) begin
            case (ex_mem_q.funct3[1:0])
                2'b00:   M_dm_w_en = 4'b0001 << ex_mem_q.alu_out[1:0];
                2'b01:   M_dm_w_en = 4'b0011 << {ex_mem_q.alu_out[1], 1'b0};
                default: M_dm_w_en = 4'b1111;
            endcase
        end
        ld_byte = 8'(dm_read_data >> {ex_mem_q.alu_out[1:0], 3'b000});
        ld_half = 16'(dm_read_data >> {ex_mem_q.alu_out[1], 4'b0000});
        case (ex_mem_q.funct3)
            F3Lb:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3Lh:    ld_val = {{16{ld_half[15]}}, ld_half};
            F3Lbu:   ld_val = {24'b0, ld_byte};
            F3Lhu:   ld_val = {16'b0, ld_half};
            default: ld_val = dm_read_data;
        endcase
        mem_wb_d.rd = ex_mem_q.rd;
        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.wb_data = ex_mem_q.mem_read ? ld_val : ex_mem_q.alu_out;
    end

    // Hazard control: a taken redirect overrides a load-use stall.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if_id_d = '{valid: 1'b1, pc: pc_q, inst: inst_IF};
        id_ex_next = id_ex_d;
        if (ex_taken) begin
            pc_d = ex_target;
            if_id_d = '0;
            id_ex_next = '0;
        end else if (load_use) begin
            pc_d = pc_q;
            if_id_d = if_id_q;
            id_ex_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
            if_id_q <= '0;
            id_ex_q <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q <= pc_d;
            if_id_q <= if_id_d;
            id_ex_q <= id_ex_next;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign F_im_w_en = 4'b0000;
    assign current_pc = pc_q;
    assign reg_ex_mem_alu_out_out = ex_mem_q.alu_out;
    assign reg_ex_mem_rs2_data_out = ex_mem_q.store_data;

endmodule

// File: tb/tb_rv32i_pipe_core.sv
// Directed self-checking bench for rv32i_pipe_core with behavioural IM and DM models.
module tb_rv32i_pipe_core;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_IF, dm_read_data;
    logic [3:0]  F_im_w_en, M_dm_w_en;
    logic [31:0] current_pc, reg_ex_mem_alu_out_out, reg_ex_mem_rs2_data_out;

    logic [31:0] im [0:63];
    logic [31:0] dm [0:15];
    logic        dm_clear = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    rv32i_pipe_core #(.RESET_PC(32'h0)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .inst_IF                 (inst_IF),
        .dm_read_data            (dm_read_data),
        .F_im_w_en               (F_im_w_en),
        .current_pc              (current_pc),
        .reg_ex_mem_alu_out_out  (reg_ex_mem_alu_out_out),
        .M_dm_w_en               (M_dm_w_en),
        .reg_ex_mem_rs2_data_out (reg_ex_mem_rs2_data_out)
    );

    always #5 clk = ~clk;

    assign inst_IF = (current_pc[15:8] == 8'd0) ? im[current_pc[7:2]] : Nop;
    assign dm_read_data = dm[reg_ex_mem_alu_out_out[5:2]];

    always @(posedge clk) begin
        if (dm_clear) begin
            for (int i = 0; i < 16; i++) dm[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (M_dm_w_en[b]) begin
                    dm[reg_ex_mem_alu_out_out[5:2]][b*8 +: 8] <= reg_ex_mem_rs2_data_out[b*8 +: 8];
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic clear_im();
        for (int i = 0; i < 64; i++) im[i] = Nop;
    endtask

    // Holds reset for two rising edges; returns at a falling edge with rst released.
    task automatic reset_core();
        rst = 1'b0;
        dm_clear = 1'b1;
        repeat (2) @(negedge clk);
        dm_clear = 1'b0;
        rst = 1'b1;
    endtask

    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        clear_im();
        reset_core();
        rst = 1'b0;
        steps(0);
        n_checks++;
        if (current_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", current_pc, 32'h0);
        end
        n_checks++;
        if (M_dm_w_en !== 4'b0000) begin
            n_fail++; $display("FAIL reset_dm_w_en: got %b expected 0000", M_dm_w_en);
        end
        n_checks++;
        if (reg_ex_mem_alu_out_out !== 32'h0 || reg_ex_mem_rs2_data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ex_mem: got %h/%h expected 0/0", reg_ex_mem_alu_out_out,
                     reg_ex_mem_rs2_data_out);
        end
        for (int r = 0; r < 32; r++) begin
            n_checks++;
            if (dut.regfile.registers[r] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg x%0d: got %h expected 0", r, dut.regfile.registers[r]);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            n_checks++;
            if (current_pc !== exp_pc) begin
                n_fail++; $display("FAIL release_pc[%0d]: got %h expected %h", k, current_pc, exp_pc);
            end
            steps(1);
        end
    endtask

    task automatic test_alu_chain();
        clear_im();
        im[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'h13);
        im[1] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
        im[2] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3);
        reset_core();
        steps(7);
        n_checks++;
        if (current_pc !== 32'd28) begin
            n_fail++; $display("FAIL alu_chain_pc: got %h expected %h", current_pc, 32'd28);
        end
        n_checks++;
        if (dut.regfile.registers[1] !== 32'd5) begin
            n_fail++; $display("FAIL alu_chain_x1: got %h expected 5", dut.regfile.registers[1]);
        end
        n_checks++;
        if (dut.regfile.registers[2] !== 32'd10) begin
            n_fail++; $display("FAIL alu_chain_x2: got %h expected a", dut.regfile.registers[2]);
        end
        n_checks++;
        if (dut.regfile.registers[3] !== 32'd5) begin
            n_fail++; $display("FAIL alu_chain_x3: got %h expected 5", dut.regfile.registers[3]);
        end
    endtask

    task automatic test_load_use();
        clear_im();
        im[0] = enc_i(32'd10, 5'd0, 3'b000, 5'd2, 7'h13);
        im[1] = enc_s(32'd0, 5'd2, 5'd0, 3'b010);
        im[2] = enc_i(32'd0, 5'd0, 3'b010, 5'd4, 7'h03);
        im[3] = enc_i(32'd1, 5'd4, 3'b000, 5'd5, 7'h13);
        reset_core();
        steps(5);
        n_checks++;
        if (current_pc !== 32'd16) begin
            n_fail++; $display("FAIL load_use_stall_pc: got %h expected %h", current_pc, 32'd16);
        end
        steps(5);
        n_checks++;
        if (current_pc !== 32'd36) begin
            n_fail++; $display("FAIL load_use_total_pc: got %h expected %h", current_pc, 32'd36);
        end
        n_checks++;
        if (dm[0] !== 32'd10) begin
            n_fail++; $display("FAIL load_use_dm0: got %h expected a", dm[0]);
        end
        n_checks++;
        if (dut.regfile.registers[4] !== 32'd10) begin
            n_fail++; $display("FAIL load_use_x4: got %h expected a", dut.regfile.registers[4]);
        end
        n_checks++;
        if (dut.regfile.registers[5] !== 32'd11) begin
            n_fail++; $display("FAIL load_use_x5: got %h expected b", dut.regfile.registers[5]);
        end
    endtask

    task automatic test_byte_half();
        clear_im();
        im[0] = enc_i(32'h80, 5'd0, 3'b000, 5'd6, 7'h13);
        im[1] = enc_s(32'd3, 5'd6, 5'd0, 3'b000);
        im[2] = enc_i(32'd3, 5'd0, 3'b000, 5'd7, 7'h03);
        im[3] = enc_i(32'd3, 5'd0, 3'b100, 5'd8, 7'h03);
        im[4] = enc_s(32'd2, 5'd6, 5'd0, 3'b001);
        im[5] = enc_i(32'd2, 5'd0, 3'b101, 5'd13, 7'h03);
        reset_core();
        steps(4);
        n_checks++;
        if (M_dm_w_en !== 4'b1000) begin
            n_fail++; $display("FAIL sb_w_en: got %b expected 1000", M_dm_w_en);
        end
        n_checks++;
        if (reg_ex_mem_rs2_data_out !== 32'h80808080 || reg_ex_mem_alu_out_out !== 32'd3) begin
            n_fail++;
            $display("FAIL sb_data_addr: got %h/%h expected 80808080/3",
                     reg_ex_mem_rs2_data_out, reg_ex_mem_alu_out_out);
        end
        steps(3);
        n_checks++;
        if (M_dm_w_en !== 4'b1100 || reg_ex_mem_rs2_data_out !== 32'h00800080) begin
            n_fail++;
            $display("FAIL sh_w_en_data: got %b/%h expected 1100/00800080", M_dm_w_en,
                     reg_ex_mem_rs2_data_out);
        end
        steps(5);
        n_checks++;
        if (dut.regfile.registers[7] !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_x7: got %h expected ffffff80", dut.regfile.registers[7]);
        end
        n_checks++;
        if (dut.regfile.registers[8] !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_x8: got %h expected 00000080", dut.regfile.registers[8]);
        end
        n_checks++;
        if (dut.regfile.registers[13] !== 32'h00000080) begin
            n_fail++; $display("FAIL lhu_x13: got %h expected 00000080", dut.regfile.registers[13]);
        end
        n_checks++;
        if (dm[0] !== 32'h00800000) begin
            n_fail++; $display("FAIL byte_half_dm0: got %h expected 00800000", dm[0]);
        end
    endtask

    task automatic test_control();
        clear_im();
        im[0]  = enc_b(32'd8, 5'd0, 5'd0, 3'b000);
        im[1]  = enc_i(32'd1, 5'd0, 3'b000, 5'd20, 7'h13);
        im[2]  = enc_i(32'd2, 5'd0, 3'b000, 5'd21, 7'h13);
        im[8]  = enc_j(32'd8, 5'd1);
        im[9]  = enc_i(32'd3, 5'd0, 3'b000, 5'd22, 7'h13);
        im[10] = enc_i(32'd4, 5'd0, 3'b000, 5'd23, 7'h13);
        im[11] = enc_i(32'h40, 5'd0, 3'b000, 5'd24, 7'h67);
        im[12] = enc_i(32'd5, 5'd0, 3'b000, 5'd25, 7'h13);
        im[16] = enc_i(32'd6, 5'd0, 3'b000, 5'd26, 7'h13);
        reset_core();
        steps(3);
        n_checks++;
        if (current_pc !== 32'h8) begin
            n_fail++; $display("FAIL beq_redirect_pc: got %h expected 8", current_pc);
        end
        steps(9);
        n_checks++;
        if (current_pc !== 32'h28) begin
            n_fail++; $display("FAIL jal_redirect_pc: got %h expected 28", current_pc);
        end
        steps(4);
        n_checks++;
        if (current_pc !== 32'h40) begin
            n_fail++; $display("FAIL jalr_redirect_pc: got %h expected 40", current_pc);
        end
        steps(8);
        n_checks++;
        if (dut.regfile.registers[1] !== 32'h24 || dut.regfile.registers[24] !== 32'h30) begin
            n_fail++;
            $display("FAIL link_regs: got x1=%h x24=%h expected 24/30",
                     dut.regfile.registers[1], dut.regfile.registers[24]);
        end
        n_checks++;
        if (dut.regfile.registers[20] !== 32'h0 || dut.regfile.registers[22] !== 32'h0 ||
            dut.regfile.registers[25] !== 32'h0) begin
            n_fail++;
            $display("FAIL skipped_regs: got x20=%h x22=%h x25=%h expected 0/0/0",
                     dut.regfile.registers[20], dut.regfile.registers[22],
                     dut.regfile.registers[25]);
        end
        n_checks++;
        if (dut.regfile.registers[21] !== 32'd2 || dut.regfile.registers[23] !== 32'd4 ||
            dut.regfile.registers[26] !== 32'd6) begin
            n_fail++;
            $display("FAIL target_regs: got x21=%h x23=%h x26=%h expected 2/4/6",
                     dut.regfile.registers[21], dut.regfile.registers[23],
                     dut.regfile.registers[26]);
        end
    endtask

    task automatic test_compare_shift();
        clear_im();
        im[0] = enc_i(32'hFFF, 5'd0, 3'b000, 5'd9, 7'h13);
        im[1] = enc_r(7'h00, 5'd9, 5'd0, 3'b011, 5'd10);
        im[2] = enc_r(7'h00, 5'd9, 5'd0, 3'b010, 5'd11);
        im[3] = enc_i(32'h404, 5'd9, 3'b101, 5'd12, 7'h13);
        im[4] = enc_i(32'd28, 5'd9, 3'b101, 5'd13, 7'h13);
        reset_core();
        steps(12);
        n_checks++;
        if (dut.regfile.registers[9] !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL addi_neg_x9: got %h expected ffffffff", dut.regfile.registers[9]);
        end
        n_checks++;
        if (dut.regfile.registers[10] !== 32'd1) begin
            n_fail++; $display("FAIL sltu_x10: got %h expected 1", dut.regfile.registers[10]);
        end
        n_checks++;
        if (dut.regfile.registers[11] !== 32'd0) begin
            n_fail++; $display("FAIL slt_x11: got %h expected 0", dut.regfile.registers[11]);
        end
        n_checks++;
        if (dut.regfile.registers[12] !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL srai_x12: got %h expected ffffffff", dut.regfile.registers[12]);
        end
        n_checks++;
        if (dut.regfile.registers[13] !== 32'h0000000F) begin
            n_fail++; $display("FAIL srli_x13: got %h expected 0000000f", dut.regfile.registers[13]);
        end
    endtask

    task automatic test_mid_reset();
        clear_im();
        im[0] = enc_i(32'h80, 5'd0, 3'b000, 5'd6, 7'h13);
        im[1] = enc_s(32'd3, 5'd6, 5'd0, 3'b000);
        im[2] = enc_i(32'd3, 5'd0, 3'b000, 5'd7, 7'h03);
        reset_core();
        steps(6);
        rst = 1'b0;
        steps(1);
        n_checks++;
        if (current_pc !== 32'h0 || M_dm_w_en !== 4'b0000 || reg_ex_mem_alu_out_out !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got pc=%h en=%b alu=%h expected 0/0000/0",
                     current_pc, M_dm_w_en, reg_ex_mem_alu_out_out);
        end
        n_checks++;
        if (dut.regfile.registers[6] !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_x6: got %h expected 0", dut.regfile.registers[6]);
        end
        rst = 1'b1;
        steps(1);
        n_checks++;
        if (current_pc !== 32'h4) begin
            n_fail++; $display("FAIL mid_reset_restart_pc: got %h expected 4", current_pc);
        end
        steps(5);
        n_checks++;
        if (dut.regfile.registers[6] !== 32'h80) begin
            n_fail++; $display("FAIL mid_reset_rerun_x6: got %h expected 80", dut.regfile.registers[6]);
        end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_byte_half();
        test_control();
        test_compare_shift();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
